// File: rtl/fsqrt_sched_if.sv
// Requester-side bundle for the shared fsqrt scheduler: operand handshake plus result stream.
// Latency: none (wires only).
// Backpressure: ready qualifies operand issue, res_ready pops the result head.
interface fsqrt_sched_if;
    logic        valid;
    logic        ready;
    logic [31:0] x;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_y;

    modport master (
        output valid, x, res_ready,
        input  ready, res_valid, res_y
    );

    modport slave (
        input  valid, x, res_ready,
        output ready, res_valid, res_y
    );
endinterface

// File: rtl/fsqrt_sched.sv
// Round-robin sharing of one pipelined fsqrt between requesters A and B, results steered to per-requester FIFOs.
// Latency: operand accepted at edge n is at its FIFO head after edge n+LAT+1.
// Backpressure: credits (in-flight + queued) per requester cap at RDEPTH, so the fsqrt never stalls and no result drops.
module fsqrt_sched #(
    parameter int LAT    = 4,
    parameter int RDEPTH = 4
) (
    input  logic               CLKA,
    input  logic               RST,
    fsqrt_sched_if.slave       a,
    fsqrt_sched_if.slave       b,
    output logic [31:0]        sq_x,
    output logic               sq_en,
    input  logic [31:0]        sq_y,
    output logic               busy
);

    localparam int PW = $clog2(RDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CLIM = CW'(RDEPTH);
    localparam logic [CW-1:0] CONE = CW'(1);
    localparam logic [PW:0]   PONE = (PW+1)'(1);

    typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_t;

    req_t              last_grant;
    logic [CW-1:0]     cnt_a, cnt_b;
    logic              elig_a, elig_b;
    logic              grant_a, grant_b, issue;

    // Stage 0 lines up with sq_x; stage LAT lines up with the matching sq_y.
    logic [LAT:0]      tag_vld;
    logic [LAT:0]      tag_id;   // 1 = B
    logic              push_a, push_b, pop_a, pop_b;

    logic [31:0]       mem_a [RDEPTH];
    logic [31:0]       mem_b [RDEPTH];
    logic [PW:0]       wp_a, rp_a, wp_b, rp_b;

    // Eligibility from registered credit counts, then round-robin pick favouring the requester not served last.
    always_comb begin
        elig_a  = 1'b0;
        elig_b  = 1'b0;
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!RST) begin
            elig_a = a.valid && (cnt_a < CLIM);
            elig_b = b.valid && (cnt_b < CLIM);
        end
        grant_a = elig_a && (!elig_b || (last_grant == REQ_B));
        grant_b = elig_b && (!elig_a || (last_grant == REQ_A));
    end

    assign issue   = grant_a || grant_b;
    assign a.ready = grant_a;
    assign b.ready = grant_b;

    assign push_a  = tag_vld[LAT] && !tag_id[LAT];
    assign push_b  = tag_vld[LAT] &&  tag_id[LAT];

    assign a.res_valid = (wp_a != rp_a);
    assign b.res_valid = (wp_b != rp_b);
    assign a.res_y     = mem_a[rp_a[PW-1:0]];
    assign b.res_y     = mem_b[rp_b[PW-1:0]];
    assign pop_a       = a.res_valid && a.res_ready;
    assign pop_b       = b.res_valid && b.res_ready;

    assign busy = (|tag_vld) || a.res_valid || b.res_valid;

    // Operand register, issue strobe and round-robin history.
    always_ff @(posedge CLKA or posedge RST) begin
        if (RST) begin
            sq_x       <= 32'h0;
            sq_en      <= 1'b0;
            last_grant <= REQ_B;
        end else begin
            sq_en <= issue;
            if (grant_a) begin
                sq_x       <= a.x;
                last_grant <= REQ_A;
            end else if (grant_b) begin
                sq_x       <= b.x;
                last_grant <= REQ_B;
            end
        end
    end

    // Tag pipeline shifts every cycle; bubbles enter as invalid tags.
    always_ff @(posedge CLKA or posedge RST) begin
        if (RST) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld <= {tag_vld[LAT-1:0], issue};
            tag_id  <= {tag_id[LAT-1:0], grant_b};
        end
    end

    // Credit counters: issue takes a credit, pop returns it, both together cancel.
    always_ff @(posedge CLKA or posedge RST) begin
        if (RST) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            case ({grant_a, pop_a})
                2'b10:   cnt_a <= cnt_a + CONE;
                2'b01:   cnt_a <= cnt_a - CONE;
                default: cnt_a <= cnt_a;
            endcase
            case ({grant_b, pop_b})
                2'b10:   cnt_b <= cnt_b + CONE;
                2'b01:   cnt_b <= cnt_b - CONE;
                default: cnt_b <= cnt_b;
            endcase
        end
    end

    // FIFO pointers with a wrap bit so full and empty are distinguishable.
    always_ff @(posedge CLKA or posedge RST) begin
        if (RST) begin
            wp_a <= '0;
            rp_a <= '0;
            wp_b <= '0;
            rp_b <= '0;
        end else begin
            if (push_a) wp_a <= wp_a + PONE;
            if (pop_a)  rp_a <= rp_a + PONE;
            if (push_b) wp_b <= wp_b + PONE;
            if (pop_b)  rp_b <= rp_b + PONE;
        end
    end

    // FIFO storage; contents are meaningless once pointers reset.
    always_ff @(posedge CLKA) begin
        if (push_a) mem_a[wp_a[PW-1:0]] <= sq_y;
        if (push_b) mem_b[wp_b[PW-1:0]] <= sq_y;
    end

endmodule
